// File: rtl/menu_screen_overlay.sv
// Full-screen menu/splash overlay: streams a ROM image into a frame window and
// draws a blinking highlight bar over the current choice, driven by up/down/select.
module menu_screen_overlay #(
  parameter int unsigned COLOR_W      = 12,
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned IMG_W        = 600,
  parameter int unsigned IMG_H        = 450,
  parameter int unsigned X0           = 20,
  parameter int unsigned Y0           = 15,
  parameter int unsigned ROM_LAT      = 1,
  parameter int unsigned NUM_CHOICES  = 2,
  parameter int unsigned CH_Y0        = 300,
  parameter int unsigned CH_PITCH     = 40,
  parameter int unsigned CH_H         = 24,
  parameter int unsigned BLINK_FRAMES = 16,
  parameter logic [COLOR_W-1:0] BG_COLOR = {COLOR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               over,
  input  logic               frame_tick,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_sel,
  input  logic [9:0]         x,
  input  logic [8:0]         y,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [COLOR_W-1:0] color,
  output logic               active,
  output logic [2:0]         choice,
  output logic               done
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, DONE = 2'd2, HOLD = 2'd3} state_t;

  localparam logic [2:0]  LAST_CH    = 3'(NUM_CHOICES - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

  state_t      state;
  logic        up_q, down_q, sel_q;
  logic        up_e, down_e, sel_e;
  logic [15:0] blink_cnt;
  logic        phase;

  logic [31:0]        x_w, y_w, bar_top;
  logic               in_win, in_bar;
  logic [ADDR_W-1:0]  lin_addr;
  logic [ROM_LAT:0]   win_d, bar_d;

  assign up_e   = btn_up   & ~up_q;
  assign down_e = btn_down & ~down_q;
  assign sel_e  = btn_sel  & ~sel_q;

  assign x_w      = {22'd0, x};
  assign y_w      = {23'd0, y};
  assign bar_top  = CH_Y0 + {29'd0, choice} * CH_PITCH;
  assign in_win   = (x_w >= X0) && (x_w < X0 + IMG_W) && (y_w >= Y0) && (y_w < Y0 + IMG_H);
  assign in_bar   = (y_w >= bar_top) && (y_w < bar_top + CH_H);
  assign lin_addr = ADDR_W'((y_w - Y0) * IMG_W + (x_w - X0));

  // Menu FSM, button edge detection and blink timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      active    <= 1'b0;
      choice    <= 3'd0;
      done      <= 1'b0;
      blink_cnt <= 16'd0;
      phase     <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      up_q   <= btn_up;
      down_q <= btn_down;
      sel_q  <= btn_sel;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (over) begin
            state     <= SHOW;
            active    <= 1'b1;
            choice    <= 3'd0;
            blink_cnt <= 16'd0;
            phase     <= 1'b1;
          end else begin
            active <= 1'b0;
          end
        end
        SHOW: begin
          if (!over) begin
            state  <= IDLE;
            active <= 1'b0;
          end else if (sel_e) begin
            state <= DONE;
            done  <= 1'b1;
            phase <= 1'b1;
          end else begin
            // simultaneous up and down edges cancel out
            if (up_e && !down_e && choice != 3'd0) begin
              choice <= choice - 3'd1;
            end else if (down_e && !up_e && choice != LAST_CH) begin
              choice <= choice + 3'd1;
            end else begin
              choice <= choice;
            end
            if (frame_tick) begin
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= 16'd0;
                phase     <= ~phase;
              end else begin
                blink_cnt <= blink_cnt + 16'd1;
              end
            end else begin
              blink_cnt <= blink_cnt;
            end
          end
        end
        DONE: begin
          if (over) begin
            state <= HOLD;
          end else begin
            state  <= IDLE;
            active <= 1'b0;
          end
        end
        HOLD: begin
          if (!over) begin
            state  <= IDLE;
            active <= 1'b0;
          end else begin
            state <= HOLD;
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

  // Pixel pipeline: S1 address/window compare, window flags delayed to meet rom_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= {ADDR_W{1'b0}};
      win_d    <= '0;
      bar_d    <= '0;
      color    <= {COLOR_W{1'b0}};
    end else begin
      rom_addr <= in_win ? lin_addr : {ADDR_W{1'b0}};
      win_d    <= {win_d[ROM_LAT-1:0], in_win};
      bar_d    <= {bar_d[ROM_LAT-1:0], in_bar};
      if (state == IDLE) begin
        color <= {COLOR_W{1'b0}};
      end else if (win_d[ROM_LAT]) begin
        color <= (bar_d[ROM_LAT] && phase) ? ~rom_data : rom_data;
      end else begin
        color <= BG_COLOR;
      end
    end
  end

endmodule

// File: tb/tb_menu_screen_overlay.sv
// Self-checking bench for menu_screen_overlay: randomized pixels and buttons
// compared against a behavioural model of the menu and image window.
module tb_menu_screen_overlay;

  logic        clk = 1'b0;
  logic        rst_n, over, frame_tick, btn_up, btn_down, btn_sel;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [18:0] rom_addr;
  logic [11:0] rom_data = 12'h000;
  logic [11:0] color;
  logic        active, done;
  logic [2:0]  choice;

  int checks = 0;
  int errors = 0;

  // model of the menu as seen from outside
  int m_choice = 0;
  int m_ticks  = 0;
  bit m_active = 1'b0;
  bit m_show   = 1'b0;
  bit m_hold   = 1'b0;

  always #5 clk = ~clk;

  menu_screen_overlay dut (
    .clk(clk), .rst_n(rst_n), .over(over), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .x(x), .y(y), .rom_addr(rom_addr), .rom_data(rom_data),
    .color(color), .active(active), .choice(choice), .done(done)
  );

  function automatic logic [11:0] rom_img(input logic [18:0] a);
    return a[11:0] ^ {a[18:12], 5'd0} ^ 12'h5a3;
  endfunction

  always @(posedge clk) rom_data <= rom_img(rom_addr);

  function automatic bit in_window(input int px, input int py);
    return (px >= 20) && (px < 620) && (py >= 15) && (py < 465);
  endfunction

  function automatic logic [18:0] exp_addr(input int px, input int py);
    int lin;
    lin = (py - 15) * 600 + (px - 20);
    return in_window(px, py) ? lin[18:0] : 19'd0;
  endfunction

  function automatic logic [11:0] exp_color(input int px, input int py);
    logic [11:0] d;
    bit bar, ph;
    if (!m_active) return 12'h000;
    if (!in_window(px, py)) return 12'h000;
    d   = rom_img(exp_addr(px, py));
    bar = (py >= 300 + m_choice * 40) && (py < 300 + m_choice * 40 + 24);
    ph  = m_hold ? 1'b1 : (((m_ticks / 16) % 2) == 0);
    return (bar && ph) ? ~d : d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int px, input int py);
    logic [18:0] ea;
    logic [11:0] ec;
    x = 10'(px);
    y = 9'(py);
    ea = exp_addr(px, py);
    tick();
    checks++;
    if (rom_addr !== ea) begin
      errors++;
      $display("FAIL pix_addr (%0d,%0d) got %0d exp %0d", px, py, rom_addr, ea);
    end
    tick();
    tick();
    ec = exp_color(px, py);
    checks++;
    if (color !== ec) begin
      errors++;
      $display("FAIL pix_color (%0d,%0d) got %h exp %h", px, py, color, ec);
    end
  endtask

  task automatic rand_pixels(input int n);
    logic [11:0] qc[$];
    logic [11:0] ec;
    logic [18:0] ea;
    int px, py;
    for (int i = 0; i < n + 2; i++) begin
      ea = 19'd0;
      if (i < n) begin
        px = $urandom_range(0, 639);
        py = ($urandom_range(0, 1) == 1) ? $urandom_range(280, 380) : $urandom_range(0, 479);
        x = 10'(px);
        y = 9'(py);
        ea = exp_addr(px, py);
        qc.push_back(exp_color(px, py));
      end
      tick();
      if (i < n) begin
        checks++;
        if (rom_addr !== ea) begin
          errors++;
          $display("FAIL rand_addr (%0d,%0d) got %0d exp %0d", px, py, rom_addr, ea);
        end
      end
      if (i >= 2) begin
        ec = qc.pop_front();
        checks++;
        if (color !== ec) begin
          errors++;
          $display("FAIL rand_color sample %0d got %h exp %h", i - 2, color, ec);
        end
      end
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
      if (m_show) m_ticks++;
    end
  endtask

  task automatic press(input bit u, input bit d);
    btn_up = u;
    btn_down = d;
    tick();
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick();
    if (u && !d && m_choice > 0) m_choice--;
    else if (d && !u && m_choice < 1) m_choice++;
    checks++;
    if (choice !== 3'(m_choice)) begin
      errors++;
      $display("FAIL press up=%0d down=%0d got %0d exp %0d", u, d, choice, m_choice);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (active !== 1'b0 || choice !== 3'd0 || done !== 1'b0 || color !== 12'h000 || rom_addr !== 19'd0) begin
      errors++;
      $display("FAIL reset_state got a=%b c=%0d d=%b col=%h addr=%0d exp 0s", active, choice, done, color, rom_addr);
    end
    rst_n = 1'b1;
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_clk got %b exp 0", active);
    end
    tick();
    m_active = 1'b1; m_show = 1'b1; m_hold = 1'b0; m_choice = 0; m_ticks = 0;
    checks++;
    if (active !== 1'b1 || choice !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_enter_show got a=%b c=%0d d=%b exp 1 0 0", active, choice, done);
    end
    tick();
    tick();
    checks++;
    if (choice !== 3'd0) begin
      errors++;
      $display("FAIL held_down_through_reset got %0d exp 0", choice);
    end
    btn_down = 1'b0;
    tick();
  endtask

  task automatic test_pixels();
    pix(20, 15);
    checks++;
    if (rom_addr !== 19'd0) begin
      errors++;
      $display("FAIL first_pixel_addr got %0d exp 0", rom_addr);
    end
    pix(619, 464);
    pix(620, 100);
    pix(19, 15);
    pix(20, 14);
    pix(100, 465);
    rand_pixels(150);
  endtask

  task automatic test_blink();
    frames(15);
    pix(100, 310);
    pix(100, 299);
    pix(100, 323);
    frames(1);
    pix(100, 310);
    pix(100, 200);
    frames(16);
    pix(100, 305);
    rand_pixels(60);
  endtask

  task automatic test_nav();
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    press(1'b0, 1'b1);
    rand_pixels(100);
  endtask

  task automatic test_select();
    int n_done;
    btn_down = 1'b1;
    tick();
    tick();
    if (m_choice < 1) m_choice++;
    btn_sel = 1'b1;
    tick();
    checks++;
    if (done !== 1'b1 || choice !== 3'(m_choice)) begin
      errors++;
      $display("FAIL select_pulse got d=%b c=%0d exp 1 %0d", done, choice, m_choice);
    end
    btn_sel = 1'b0;
    m_show = 1'b0;
    m_hold = 1'b1;
    n_done = 0;
    repeat (6) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0 || active !== 1'b1) begin
      errors++;
      $display("FAIL hold_state got extra_done=%0d active=%b exp 0 1", n_done, active);
    end
    btn_down = 1'b0;
    btn_up = 1'b1;
    tick();
    btn_up = 1'b0;
    tick();
    checks++;
    if (choice !== 3'(m_choice)) begin
      errors++;
      $display("FAIL hold_ignores_buttons got %0d exp %0d", choice, m_choice);
    end
    frames(16);
    pix(100, 300 + m_choice * 40 + 5);
    over = 1'b0;
    tick();
    m_active = 1'b0;
    m_hold = 1'b0;
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL hold_to_idle got active=%b exp 0", active);
    end
    pix(100, 310);
    pix(300, 200);
  endtask

  task automatic test_over_drop();
    int n_done;
    over = 1'b1;
    tick();
    m_active = 1'b1; m_show = 1'b1; m_hold = 1'b0; m_choice = 0; m_ticks = 0;
    checks++;
    if (active !== 1'b1 || choice !== 3'd0) begin
      errors++;
      $display("FAIL reenter_show got a=%b c=%0d exp 1 0", active, choice);
    end
    press(1'b0, 1'b1);
    over = 1'b0;
    n_done = 0;
    tick();
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL over_drop got active=%b exp 0", active);
    end
    repeat (4) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    m_active = 1'b0; m_show = 1'b0;
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL over_drop_no_done got %0d pulses exp 0", n_done);
    end
    over = 1'b1;
    tick();
    btn_sel = 1'b1;
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_before_reset got %b exp 1", done);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || active !== 1'b0 || choice !== 3'd0 || color !== 12'h000 || rom_addr !== 19'd0) begin
      errors++;
      $display("FAIL async_reset_in_done got d=%b a=%b c=%0d col=%h addr=%0d exp 0s", done, active, choice, color, rom_addr);
    end
    tick();
    rst_n = 1'b1;
    n_done = 0;
    repeat (4) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0 || active !== 1'b1) begin
      errors++;
      $display("FAIL sel_held_through_reset got done=%0d active=%b exp 0 1", n_done, active);
    end
    btn_sel = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; over = 1'b1; frame_tick = 1'b0;
    btn_up = 1'b0; btn_down = 1'b1; btn_sel = 1'b0;
    x = 10'd0; y = 9'd0;
    repeat (3) tick();
    test_reset();
    test_pixels();
    test_blink();
    test_nav();
    test_select();
    test_over_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
